// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped
// write-back data cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    DONE
  } state_e;

  localparam int OFFSET_LSB     = 2;
  localparam int INDEX_LSB      = 5;
  localparam int WORDS_PER_LINE = 8;
  localparam int LINE_W         = 32 * WORDS_PER_LINE;

  function automatic logic [LINE_W-1:0] put_word(
    input logic [LINE_W-1:0] line,
    input logic [2:0]        off,
    input logic [31:0]       word
  );
    logic [LINE_W-1:0] r;
    r = line;
    r[{off, 5'b00000} +: 32] = word;
    return r;
  endfunction

  function automatic logic [31:0] get_word(
    input logic [LINE_W-1:0] line,
    input logic [2:0]        off
  );
    return line[{off, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid/dirty/tag storage: one combinational read port,
// one write port; valid and dirty clear asynchronously.
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic             wr_dirty,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (we) begin
      valid_d[wr_idx] = wr_valid;
      dirty_d[wr_idx] = wr_dirty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tags need no reset: a line is only trusted when valid.
  always_ff @(posedge clk) begin
    if (we) tag_q[wr_idx] <= wr_tag;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate D-cache controller.
// Define DCACHE_STATS_EN to add hit_count/miss_count outputs.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int BLOCK_W   = 256,
  parameter int ADDR_W    = 32
) (
  input  logic               CLK,
  input  logic               RESET,
`ifdef DCACHE_STATS_EN
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count,
`endif
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [ADDR_W-1:0]  data_address_2DM,
  input  logic [31:0]        data_write_2DM,
  output logic [31:0]        data_read_fDM,
  output logic               FREEZE,
  output logic               dBlkRead,
  output logic               dBlkWrite,
  output logic [ADDR_W-1:0]  dBlk_address,
  output logic [BLOCK_W-1:0] block_write_2DM,
  input  logic [BLOCK_W-1:0] block_read_fDM,
  input  logic               dBlk_ready
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - INDEX_LSB - IDX_W;

  logic [2:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_bits;

  assign off = data_address_2DM[INDEX_LSB-1:OFFSET_LSB];
  assign idx = data_address_2DM[INDEX_LSB +: IDX_W];
  assign tag = data_address_2DM[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^data_address_2DM[1:0];

  state_e state_q, state_d;

  logic               rd_valid, rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  logic               tag_we, tag_wdirty;
  logic [TAG_W-1:0]   tag_wtag;

  logic [BLOCK_W-1:0] data_q [NUM_LINES];
  logic               data_we;
  logic [BLOCK_W-1:0] data_d;
  logic [BLOCK_W-1:0] cur_line;

  logic               req, hit, wr_hit, freeze;

  logic               dblk_read_q, dblk_read_d;
  logic               dblk_write_q, dblk_write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] blk_wr_q, blk_wr_d;

  dcache_tag_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_tags (
    .clk      (CLK),
    .rst_n    (RESET),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .we       (tag_we),
    .wr_idx   (idx),
    .wr_valid (1'b1),
    .wr_dirty (tag_wdirty),
    .wr_tag   (tag_wtag)
  );

  assign cur_line = data_q[idx];
  assign req      = MemRead | MemWrite;
  assign hit      = req & rd_valid & (rd_tag == tag);
  assign wr_hit   = hit & MemWrite;

  always_comb begin
    state_d    = state_q;
    freeze     = 1'b0;
    tag_we     = 1'b0;
    tag_wdirty = 1'b0;
    tag_wtag   = tag;
    data_we    = 1'b0;
    data_d     = put_word(cur_line, off, data_write_2DM);
    unique case (state_q)
      IDLE: begin
        if (wr_hit) begin
          tag_we     = 1'b1;
          tag_wdirty = 1'b1;
          data_we    = 1'b1;
        end else if (req && !hit) begin
          freeze  = 1'b1;
          state_d = (rd_valid && rd_dirty) ? WB : FILL;
        end
      end
      WB: begin
        freeze = 1'b1;
        if (dBlk_ready) begin
          tag_we   = 1'b1;
          tag_wtag = rd_tag;
          state_d  = FILL;
        end
      end
      FILL: begin
        freeze = 1'b1;
        // Only a response to an issued read completes the fill.
        if (dBlk_ready && dblk_read_q) begin
          tag_we  = 1'b1;
          data_we = 1'b1;
          data_d  = block_read_fDM;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (wr_hit) begin
          tag_we     = 1'b1;
          tag_wdirty = 1'b1;
          data_we    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One idle turnaround cycle separates a writeback from its refill.
  always_comb begin
    dblk_write_d = (state_d == WB);
    dblk_read_d  = (state_d == FILL) && (state_q != WB);
    addr_d       = addr_q;
    blk_wr_d     = blk_wr_q;
    if (state_q == IDLE && state_d == WB) begin
      addr_d   = {rd_tag, idx, 5'b00000};
      blk_wr_d = cur_line;
    end
    if (state_q != FILL && state_d == FILL) begin
      addr_d = {tag, idx, 5'b00000};
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      dblk_read_q  <= 1'b0;
      dblk_write_q <= 1'b0;
      addr_q       <= '0;
      blk_wr_q     <= '0;
    end else begin
      state_q      <= state_d;
      dblk_read_q  <= dblk_read_d;
      dblk_write_q <= dblk_write_d;
      addr_q       <= addr_d;
      blk_wr_q     <= blk_wr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (data_we) data_q[idx] <= data_d;
  end

  assign data_read_fDM   = (MemRead && hit) ? get_word(cur_line, off) : '0;
  assign FREEZE          = freeze & RESET;
  assign dBlkRead        = dblk_read_q;
  assign dBlkWrite       = dblk_write_q;
  assign dBlk_address    = addr_q;
  assign block_write_2DM = blk_wr_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && hit && hit_cnt_q != '1)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == IDLE && req && !hit && miss_cnt_q != '1)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random
// accesses checked against a line-level cache/memory model.
module tb_dcache_ctrl;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         MemRead, MemWrite;
  logic [31:0]  data_address_2DM, data_write_2DM;
  logic [31:0]  data_read_fDM;
  logic         FREEZE, dBlkRead, dBlkWrite;
  logic [31:0]  dBlk_address;
  logic [255:0] block_write_2DM, block_read_fDM;
  logic         dBlk_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
  int           exp_hits, exp_misses;
`endif

  int checks = 0;
  int errors = 0;

  bit           mv [16];
  bit           md [16];
  logic [22:0]  mt [16];
  logic [255:0] ml [16];
  logic [255:0] mem [int unsigned];

  dcache_ctrl dut (
    .CLK              (CLK),
    .RESET            (RESET),
`ifdef DCACHE_STATS_EN
    .hit_count        (hit_count),
    .miss_count       (miss_count),
`endif
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .data_address_2DM (data_address_2DM),
    .data_write_2DM   (data_write_2DM),
    .data_read_fDM    (data_read_fDM),
    .FREEZE           (FREEZE),
    .dBlkRead         (dBlkRead),
    .dBlkWrite        (dBlkWrite),
    .dBlk_address     (dBlk_address),
    .block_write_2DM  (block_write_2DM),
    .block_read_fDM   (block_read_fDM),
    .dBlk_ready       (dBlk_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tg,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic mem_get(input int unsigned blk,
                         output logic [255:0] v);
    if (!mem.exists(blk)) mem[blk] = rnd256();
    v = mem[blk];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
`ifdef DCACHE_STATS_EN
    exp_hits   = 0;
    exp_misses = 0;
`endif
  endtask

  task automatic access(input logic [31:0] a, input bit wr,
                        input logic [31:0] wd, input int tm1,
                        input int tm2, input bit spur);
    int           idx, off, fz;
    logic [22:0]  tg;
    bit           mh, wbk;
    logic [31:0]  vaddr;
    logic [255:0] fill;
    idx = int'(a[8:5]);
    off = int'(a[4:2]);
    tg  = a[31:9];
    mh  = mv[idx] && (mt[idx] == tg);
    wbk = !mh && mv[idx] && md[idx];
    @(negedge CLK);
    MemRead  = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
    MemWrite = wr;
    data_address_2DM = a;
    data_write_2DM   = wd;
    dBlk_ready       = spur;
    #1;
    if (mh) begin
      chk("hit_freeze", FREEZE, 0);
      chk("hit_strobes", {dBlkRead, dBlkWrite}, 0);
      if (!wr) chk("hit_data", data_read_fDM, ml[idx][off*32 +: 32]);
`ifdef DCACHE_STATS_EN
      exp_hits++;
`endif
    end else begin
      chk("miss_freeze", FREEZE, 1);
      fz = 1;
`ifdef DCACHE_STATS_EN
      exp_misses++;
`endif
      @(posedge CLK); #1 dBlk_ready = 1'b0;
      @(negedge CLK);
      if (wbk) begin
        vaddr = {mt[idx], a[8:5], 5'b00000};
        for (int i = 1; i <= tm1; i++) begin
          chk("wb_write", dBlkWrite, 1);
          chk("wb_read", dBlkRead, 0);
          chk("wb_addr", dBlk_address, vaddr);
          chk("wb_data", block_write_2DM, ml[idx]);
          fz += int'(FREEZE);
          if (i == tm1) dBlk_ready = 1'b1;
          @(posedge CLK); #1 dBlk_ready = 1'b0;
          @(negedge CLK);
        end
        mem[vaddr >> 5] = ml[idx];
        md[idx] = 1'b0;
        chk("turn_strobes", {dBlkRead, dBlkWrite}, 0);
        fz += int'(FREEZE);
        @(posedge CLK);
        @(negedge CLK);
      end
      mem_get(a >> 5, fill);
      for (int i = 1; i <= tm2; i++) begin
        chk("fill_read", dBlkRead, 1);
        chk("fill_write", dBlkWrite, 0);
        chk("fill_addr", dBlk_address, {a[31:5], 5'b00000});
        fz += int'(FREEZE);
        if (i == tm2) begin
          dBlk_ready     = 1'b1;
          block_read_fDM = fill;
        end
        @(posedge CLK); #1 dBlk_ready = 1'b0;
        block_read_fDM = rnd256();
        @(negedge CLK);
      end
      ml[idx] = fill;
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
      mt[idx] = tg;
      chk("freeze_cycles", fz, (wbk ? 1 + tm1 : 0) + 1 + tm2);
      chk("done_freeze", FREEZE, 0);
      chk("done_strobes", {dBlkRead, dBlkWrite}, 0);
      if (!wr) chk("done_data", data_read_fDM, ml[idx][off*32 +: 32]);
    end
    if (wr) begin
      ml[idx][off*32 +: 32] = wd;
      md[idx] = 1'b1;
    end
    @(posedge CLK); #1;
    dBlk_ready = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
  endtask

  initial begin
    logic [255:0] seed_line;
    logic [31:0]  ra;
    RESET = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    data_address_2DM = '0;
    data_write_2DM = '0;
    block_read_fDM = '0;
    dBlk_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_freeze", FREEZE, 0);
    chk("rst_strobes", {dBlkRead, dBlkWrite}, 0);
    chk("rst_addr", dBlk_address, 0);
    chk("rst_blk", block_write_2DM, 0);
    chk("idle_data", data_read_fDM, 0);
    @(negedge CLK) RESET = 1'b1;

    seed_line = rnd256();
    seed_line[31:0] = 32'hDEADBEEF;
    mem[32'h100 >> 5] = seed_line;
    access(32'h100, 1'b0, '0, 1, 3, 1'b0);
    access(32'h104, 1'b1, 32'h12345678, 1, 1, 1'b0);
    access(32'h104, 1'b0, '0, 1, 1, 1'b0);
    chk("word0", ml[8][31:0], 32'hDEADBEEF);
`ifdef DCACHE_STATS_EN
    chk("stat_miss1", miss_count, 1);
    chk("stat_hit2", hit_count, 2);
`endif
    access(32'h300, 1'b0, '0, 2, 2, 1'b0);
    chk("wb_word1", mem[32'h100 >> 5][63:32], 32'h12345678);

    @(negedge CLK);
    MemRead = 1'b1;
    data_address_2DM = 32'h500;
    #1 chk("rf_freeze", FREEZE, 1);
    @(posedge CLK);
    @(negedge CLK);
    chk("rf_read", dBlkRead, 1);
    chk("rf_addr", dBlk_address, 32'h500);
    RESET = 1'b0;
    #1;
    chk("rf_rst_freeze", FREEZE, 0);
    chk("rf_rst_strobes", {dBlkRead, dBlkWrite}, 0);
    chk("rf_rst_addr", dBlk_address, 0);
    chk("rf_rst_blk", block_write_2DM, 0);
    @(posedge CLK); #1;
    chk("rf_rst_hold", dBlkRead, 0);
    MemRead = 1'b0;
    @(negedge CLK) RESET = 1'b1;
    model_reset();

    access(32'h100, 1'b0, '0, 1, 2, 1'b0);
    access(32'h104, 1'b0, '0, 1, 1, 1'b1);
    access(32'h100, 1'b0, '0, 1, 1, 1'b1);
    access(32'h104, 1'b0, '0, 1, 1, 1'b1);

    for (int n = 0; n < 120; n++) begin
      ra = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5)
         | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      access(ra, ($urandom_range(0, 2) == 0), $urandom,
             $urandom_range(1, 4), $urandom_range(1, 4), 1'b0);
    end
`ifdef DCACHE_STATS_EN
    chk("stat_hits", hit_count, exp_hits);
    chk("stat_misses", miss_count, exp_misses);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
